// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU (alu_serial) and its 1-bit slice
// (alu1_slice):
//   - operation-select codes
//   - FSM state type
//   - init_carry(): carry register value loaded when an operation starts
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [1:0] OP_OR_NOTB = 2'b00;   // F = A | ~B
   localparam logic [1:0] OP_NOT_A   = 2'b01;   // F = ~A
   localparam logic [1:0] OP_INC     = 2'b10;   // F = A + 1
   localparam logic [1:0] OP_ADD     = 2'b11;   // F = A + B + CarryIn

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Carry seeded into the slice for bit 0. Increment is an add of a
   // constant 1 folded into the carry, so B can be ignored for that op.
   function automatic logic init_carry(input logic [1:0] op, input logic cin);
      logic c;
      case (op)
         OP_INC:  c = 1'b1;
         OP_ADD:  c = cin;
         default: c = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu1_slice.sv
// -----------------------------------------------------------------------------
// alu1_slice
// Combinational 1-bit ALU slice used once per clock by alu_serial.
// Ports:
//   S    [1:0] in  operation select (alu_pkg OP_* codes)
//   a          in  operand A bit
//   b          in  operand B bit (ignored by OP_NOT_A and OP_INC)
//   cin        in  carry in
//   f          out result bit
//   cout       out carry out (always 0 for the logic ops)
// -----------------------------------------------------------------------------
module alu1_slice
   import alu_pkg::*;
(
   input  logic [1:0] S,
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   output logic       f,
   output logic       cout
);

   always_comb begin
      f    = 1'b0;
      cout = 1'b0;
      case (S)
         OP_OR_NOTB: f = a | ~b;
         OP_NOT_A:   f = ~a;
         OP_INC: begin
            // half adder: the +1 arrives through cin
            f    = a ^ cin;
            cout = a & cin;
         end
         default: begin
            f    = a ^ b ^ cin;
            cout = (a & b) | (a & cin) | (b & cin);
         end
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// -----------------------------------------------------------------------------
// alu_serial
// Bit-serial ALU: processes WIDTH-bit operands one bit per clock, LSB first,
// through a single alu1_slice plus a carry register.
// Handshake: Start (sampled in IDLE only) -> Busy for WIDTH cycles ->
// one-cycle Done pulse. F/CarryOut are registered and change only at the
// completion edge, holding their value through the next operation.
// Ports:
//   Clock           in   rising-edge clock
//   ResetN          in   asynchronous active-low reset
//   Start           in   operation request
//   S [1:0]         in   operation select, sampled with Start
//   A,B [WIDTH-1:0] in   operands, sampled with Start
//   CarryIn         in   carry in for OP_ADD, sampled with Start
//   Busy            out  high while bits are being processed
//   Done            out  one-cycle completion pulse
//   F [WIDTH-1:0]   out  registered result
//   CarryOut        out  registered carry out of the MSB
// Optional (macro ALU_SERIAL_FLAGS_EN defined):
//   Zero            out  registered (F == 0)
//   Overflow        out  registered signed overflow for OP_INC/OP_ADD
// Parameter: WIDTH (2..32), default 8.
// -----------------------------------------------------------------------------
module alu_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             ResetN,
   input  logic             Start,
   input  logic [1:0]       S,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CarryIn,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] F,
   output logic             CarryOut
`ifdef ALU_SERIAL_FLAGS_EN
   ,
   output logic             Zero,
   output logic             Overflow
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [1:0]       r_op;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_f;
   logic             w_cout;
   logic             w_last;
   logic [WIDTH-1:0] w_res_next;

   alu1_slice u_slice (
      .S    (r_op),
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry),
      .f    (w_f),
      .cout (w_cout)
   );

   assign w_last     = (r_cnt == LAST_BIT);
   // result fills from the top so that after WIDTH shifts bit 0 is at the LSB
   assign w_res_next = {w_f, r_res[WIDTH-1:1]};

   // ---------------- FSM: state register ----------------
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (Start) w_state_next = SHIFT;
         SHIFT:   if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      case (r_state)
         SHIFT:   Busy = 1'b1;
         DONE:    Done = 1'b1;
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_op     <= OP_OR_NOTB;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         F        <= '0;
         CarryOut <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
         Zero     <= 1'b0;
         Overflow <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (Start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_op    <= S;
                  r_carry <= init_carry(S, CarryIn);
                  r_cnt   <= '0;
               end
            end
            SHIFT: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_res   <= w_res_next;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  F        <= w_res_next;
                  CarryOut <= w_cout;
`ifdef ALU_SERIAL_FLAGS_EN
                  Zero     <= (w_res_next == '0);
                  // r_carry here is the carry into the MSB
                  Overflow <= r_op[1] & (r_carry ^ w_cout);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised bit-serial successor to the team's 1-bit ALU.
- Operates on WIDTH-bit operands, one bit per clock, LSB first, through a single 1-bit slice plus a carry register.
- Start/Busy/Done handshake; result and carry registered and held until the next operation completes.
- Sits between operand registers and the result bus in the small datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
Clock  input  1  system clock, rising edge.
ResetN  input  1  asynchronous, active-low reset.
Start  input  1  request; sampled only in IDLE.
S  input  2  operation select, sampled with Start.
A  input  WIDTH  operand A, sampled with Start.
B  input  WIDTH  operand B, sampled with Start.
CarryIn  input  1  carry input; used only by op 11, sampled with Start.
Busy  output  1  high while bits are being processed.
Done  output  1  one-cycle pulse; F/CarryOut valid from this cycle.
F  output  WIDTH  registered result.
CarryOut  output  1  registered final carry.

Interface decision: one clock (Clock); reset ResetN is asynchronous and active-low.

Behaviour:
- Reset (ResetN low, asynchronous): state IDLE; Busy=0, Done=0, F=0, CarryOut=0; internal shift registers, carry and bit counter cleared. Reset mid-operation aborts the operation; no Done is produced.
- Operations, all bitwise per slice:
  - 00: F = A | ~B. CarryOut=0.
  - 01: F = ~A. CarryOut=0.
  - 10: F = A + 1. Initial carry 1; B ignored.
  - 11: F = A + B + CarryIn. Initial carry = CarryIn.
- Arithmetic is modulo 2^WIDTH; CarryOut is the carry out of the MSB.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Busy=0.
  - On Start=1: latch A, B, S and the initial carry; clear the counter; go to SHIFT.
- SHIFT:
  - Busy=1.
  - Each edge: the slice combines the LSBs of the A/B shift registers with the carry register.
  - Result bit shifts into the MSB of the internal result register; A/B shift right; the carry register updates.
  - Counter increments.
  - After the edge processing bit WIDTH-1, load F and CarryOut and go to DONE.
- DONE:
  - Done=1, Busy=0, for exactly one cycle.
  - Returns to IDLE unconditionally; Start is ignored here.
- Latency: Start sampled at edge 0. Done is high in the cycle following edge WIDTH. F and CarryOut change only at that edge.
- Start outside IDLE is ignored; operand changes during SHIFT have no effect.
- F and CarryOut hold their previous values through an entire new operation until its completion edge.
- Back-to-back operation: Start may be held high continuously. A new operation begins every WIDTH+2 cycles.

Optional Feature:
- Macro: ALU_SERIAL_FLAGS_EN.
- Defined:
  - Adds outputs Zero (1 bit) and Overflow (1 bit), registered at the same edge as F, reset 0.
  - Zero = (F == 0) for all ops.
  - Overflow = signed overflow, i.e. carry into MSB XOR carry out of MSB, for ops 10/11; 0 for ops 00/01.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Op-code constants OP_OR_NOTB=2'b00, OP_NOT_A=2'b01, OP_INC=2'b10, OP_ADD=2'b11.
  - FSM state typedef (IDLE, SHIFT, DONE).
  - Helper for initial-carry selection by op.
- Sub-module alu1_slice: combinational 1-bit slice.
  - Inputs: S, a, b, cin.
  - Outputs: f, cout.
  - cout forced 0 for logic ops.
  - Instantiated once inside alu_serial.

Test Plan (WIDTH=8):
- Op 11, A=0x7F, B=0x01, CarryIn=1, Start pulse -> Busy high 8 cycles. Done pulses in cycle after edge 8 with F=0x81, CarryOut=0. Overflow=1 with the flag macro.
- Op 10, A=0xFF, B=0x55 -> F=0x00, CarryOut=1. Zero=1 and Overflow=0 with the flag macro.
- Op 00, A=0x0F, B=0xF0 -> F=0x0F, CarryOut=0. Then op 01, A=0xA5 -> F=0x5A, CarryOut=0.
- Start op 11, A=0x01, B=0x01, CarryIn=0. Assert Start again with A=0xFF during SHIFT -> second request ignored; F=0x02. F holds its previous value until Done.
- ResetN low asynchronously after the 3rd SHIFT edge -> Busy, Done, F, CarryOut become 0 immediately, with no Done pulse. After release, op 11 with 0xFF+0x01+0 -> F=0x00, CarryOut=1.
- Start held high for 3 operations -> Done pulses every 10 cycles; each result is correct.
